resource_sched: RTL and testbench
=================================

# resource_sched

Round-robin scheduler that shares the single update port of one saturating resource counter (inc/dec/fast/setval) among NREQ requesters, such as the mood, light and water logic. It also injects a periodic decay step and a clear command. It sits directly in front of the counter instance and drives its control pins with registered single-cycle pulses. Each requester receives a one-cycle acknowledge when its command is issued.

## Interface
- NREQ, 4, number of requesters (2..8)
- DECAY_PERIOD, 1024, cycles between decay steps (≥2); only used when decay is compiled in
- CW, 11, width of decay timer; must satisfy 2^CW ≥ DECAY_PERIOD
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NREQ  request per requester; level, held until ack
- req_op  in  2*NREQ  op of requester i at bits [2i+1:2i]; bit0 = direction (0 inc, 1 dec), bit1 = fast
- clr  in  1  clear request; level
- ack  out  NREQ  one-hot, one-cycle grant pulse
- res_inc  out  1  to counter inc
- res_dec  out  1  to counter dec
- res_fast  out  1  to counter fast
- res_setval  out  1  to counter setval
- busy  out  1  high in any cycle where a command pulse is being driven

## Operation
- Reset: all outputs 0; rr pointer = 0; decay timer = 0; decay_pend = 0.
- Each cycle, arbitration selects at most one source. Priority: clr > decay_pend > requesters (round-robin).
- **clr**
  - res_setval = 1 next cycle; all other res_* = 0; ack = 0.
  - Repeats every cycle while clr is held.
  - Requests wait; decay_pend is retained.
- **decay** (DECAY_EN only)
  - Timer counts 0..DECAY_PERIOD-1 and wraps.
  - On wrap, decay_pend is set.
  - A pending decay issues res_dec=1, res_fast=0, with no ack; decay_pend then clears.
  - Timer runs regardless of clr or requests.
  - If the timer wraps while decay_pend is still set, the decay steps merge into one pending decay (not queued).
- **requesters**
  - Search starts at the rr pointer and ascends modulo NREQ; the first i with req[i]=1 wins.
  - The winner's op is decoded:
    - res_inc = ~op[0]
    - res_dec = op[0]
    - res_fast = op[1]
  - ack[i] = 1 in the same cycle as the pulses.
  - The pointer moves to (i+1) mod NREQ only on a requester grant.
- Requester rule: req and req_op must stay stable until ack. A req still high in the cycle after ack counts as a new request.
- A requester that drops req before ack is simply not granted. No error is flagged.
- res_inc and res_dec are never both 1. No res_* output is ever high together with res_setval.
- Saturation is the counter's job; the scheduler never inspects the counter value.

## Timing
- Arbitration is combinational from the inputs sampled at edge k. res_*, ack and busy are registered and valid during cycle k+1, for exactly one cycle.
- The counter value changes at edge k+2.
- Back-to-back grants are allowed, one per cycle. With all NREQ requesting, each requester is granted within NREQ cycles, plus one cycle per intervening decay or clr cycle.
- Reset asserted mid-operation: outputs drop to 0 asynchronously, pending decay is lost, and the pointer returns to 0.
- busy = |{res_inc, res_dec, res_setval}|.

## Configuration
- RESOURCE_SCHED_DECAY_EN defined: decay timer and decay_pend are present as described.
- Undefined:
  - No timer logic is built.
  - Priority reduces to clr > requesters.
  - DECAY_PERIOD and CW are ignored.

## Structure
- Shared package resource_pkg holds:
  - Op encoding constants: OP_INC=2'b00, OP_DEC=2'b01, OP_FINC=2'b10, OP_FDEC=2'b11
  - Source-select enum: SRC_NONE, SRC_CLR, SRC_DECAY, SRC_REQ
- One sub-module, rr_picker (NREQ, req vector, pointer → one-hot grant + valid), which is reusable for other shared resources.

## Test plan
- Reset: all outputs 0 while rst_n=0. After release with no req, outputs stay 0 for 20 cycles (DECAY_PERIOD=1024).
- Single requester: req[2]=1, op=OP_FINC at edge k → ack[2], res_inc=1 and res_fast=1 during cycle k+1 only.
- Fairness: req=4'b1111 held and re-asserted continuously → ack order 0,1,2,3,0,… with one grant per cycle.
- clr vs requests: clr=1 for 3 cycles with req[1]=1 → res_setval pulses for 3 cycles with no ack; ack[1] follows in the next cycle.
- Decay (DECAY_EN, DECAY_PERIOD=8, no other traffic) → res_dec=1, res_fast=0 exactly once every 8 cycles.
- Decay collision (DECAY_EN, DECAY_PERIOD=8, req[0] held from the wrap cycle) → the decay pulse is issued first and ack[0] is delayed by one cycle.
- Reset mid-operation: pulse rst_n while a decay is pending → the decay pulse is never issued and the next grant goes to requester 0.

Source files
------------

// File: rtl/resource_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | resource_pkg : op encodings and source-select type for resource_sched |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package resource_pkg;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_FINC = 2'b10;
  localparam logic [1:0] OP_FDEC = 2'b11;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_CLR   = 2'd1,
    SRC_DECAY = 2'd2,
    SRC_REQ   = 2'd3
  } src_e;

endpackage
`default_nettype wire

// File: rtl/resource_sched_rr_picker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_picker : round-robin one-hot pick, search ascends from ptr       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module rr_picker #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic            valid
);

  logic [NREQ-1:0]   rot;
  logic [NREQ-1:0]   rot_pick;
  logic [2*NREQ-1:0] back;

  // Rotate so ptr lands on bit 0, isolate the lowest set bit, rotate back.
  assign rot      = NREQ'({req, req} >> ptr);
  assign rot_pick = rot & (~rot + NREQ'(1));
  assign back     = {{NREQ{1'b0}}, rot_pick} << ptr;
  assign grant    = back[2*NREQ-1:NREQ] | back[NREQ-1:0];
  assign valid    = |req;

endmodule
`default_nettype wire

// File: rtl/resource_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | resource_sched : shares one resource counter update port among      |
// | NREQ requesters plus clear and (RESOURCE_SCHED_DECAY_EN) decay.     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module resource_sched
  import resource_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int DECAY_PERIOD = 1024,
  parameter int CW           = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_op,
  input  logic              clr,
  output logic [NREQ-1:0]   ack,
  output logic              res_inc,
  output logic              res_dec,
  output logic              res_fast,
  output logic              res_setval,
  output logic              busy
);

  localparam int PW = $clog2(NREQ);

  src_e                 src;
  logic [PW-1:0]        ptr;
  logic [NREQ-1:0]      grant;
  logic                 pick_valid;
  logic [NREQ:0][1:0]   op_acc;
  logic [NREQ:0][PW-1:0] ptr_acc;
  logic [1:0]           sel_op;
  logic [PW-1:0]        nxt_ptr;
  logic                 nxt_inc, nxt_dec, nxt_fast, nxt_setval;
  logic [NREQ-1:0]      nxt_ack;

`ifdef RESOURCE_SCHED_DECAY_EN
  logic [CW-1:0] decay_timer;
  logic          decay_pend;
  logic          decay_wrap;

  assign decay_wrap = (decay_timer == CW'(DECAY_PERIOD - 1));

  // Timer free-runs; a wrap while a step is still pending merges into it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decay_timer <= '0;
      decay_pend  <= 1'b0;
    end else begin
      decay_timer <= decay_wrap ? '0 : decay_timer + CW'(1);
      decay_pend  <= decay_wrap | (decay_pend & (src != SRC_DECAY));
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{DECAY_PERIOD[0], CW[0]};
`endif

  rr_picker #(.NREQ(NREQ), .PW(PW)) u_picker (
    .req   (req),
    .ptr   (ptr),
    .grant (grant),
    .valid (pick_valid)
  );

  // One-hot grant folded into the winner's op and the successor pointer.
  assign op_acc[0]  = '0;
  assign ptr_acc[0] = '0;
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_sel
    assign op_acc[gi+1]  = op_acc[gi] | (req_op[2*gi +: 2] & {2{grant[gi]}});
    assign ptr_acc[gi+1] = ptr_acc[gi] | (grant[gi] ? PW'((gi + 1) % NREQ) : '0);
  end
  assign sel_op  = op_acc[NREQ];
  assign nxt_ptr = ptr_acc[NREQ];

  always_comb begin
    src = SRC_NONE;
    if (clr)
      src = SRC_CLR;
`ifdef RESOURCE_SCHED_DECAY_EN
    else if (decay_pend)
      src = SRC_DECAY;
`endif
    else if (pick_valid)
      src = SRC_REQ;
  end

  always_comb begin
    nxt_inc    = 1'b0;
    nxt_dec    = 1'b0;
    nxt_fast   = 1'b0;
    nxt_setval = 1'b0;
    nxt_ack    = '0;
    case (src)
      SRC_CLR:   nxt_setval = 1'b1;
      SRC_DECAY: nxt_dec    = 1'b1;
      SRC_REQ: begin
        nxt_inc  = ~sel_op[0];
        nxt_dec  = sel_op[0];
        nxt_fast = sel_op[1];
        nxt_ack  = grant;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      ack        <= '0;
      res_inc    <= 1'b0;
      res_dec    <= 1'b0;
      res_fast   <= 1'b0;
      res_setval <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ack        <= nxt_ack;
      res_inc    <= nxt_inc;
      res_dec    <= nxt_dec;
      res_fast   <= nxt_fast;
      res_setval <= nxt_setval;
      busy       <= nxt_inc | nxt_dec | nxt_setval;
      if (src == SRC_REQ)
        ptr <= nxt_ptr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_resource_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_resource_sched : randomized scoreboard bench for resource_sched  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_resource_sched;
  import resource_pkg::*;

  localparam int NREQ = 4;
  localparam int P    = 16;
  localparam int CW   = 4;
  localparam int EW   = NREQ + 5;
`ifdef RESOURCE_SCHED_DECAY_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [2*NREQ-1:0] req_op = '0;
  logic              clr = 1'b0;
  logic [NREQ-1:0]   ack;
  logic              res_inc, res_dec, res_fast, res_setval, busy;

  resource_sched #(.NREQ(NREQ), .DECAY_PERIOD(P), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_op     (req_op),
    .clr        (clr),
    .ack        (ack),
    .res_inc    (res_inc),
    .res_dec    (res_dec),
    .res_fast   (res_fast),
    .res_setval (res_setval),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];
  bit mon_en = 1'b0;

  // Reference state: rr pointer, pending decay, edges since reset, unacked requesters.
  int              m_ptr = 0;
  int              m_tc = 0;
  bit              m_pend = 1'b0;
  logic [NREQ-1:0] waiting = '0;

  logic [EW-1:0] mon_act, mon_exp;

  initial forever begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      mon_act = {ack, res_inc, res_dec, res_fast, res_setval, busy};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: got %b with no expected entry at %0t", mon_act, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL cycle_outputs {ack,inc,dec,fast,setval,busy}: got %b expected %b at %0t",
                   mon_act, mon_exp, $time);
        end
      end
    end
  end

  task automatic drive(input logic [NREQ-1:0] rq, input logic [2*NREQ-1:0] ops,
                       input logic c, input logic [NREQ-1:0] drop);
    logic [NREQ-1:0] a;
    logic [1:0]      op;
    logic            inc, dec, fast, sv;
    bit              found, took;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (!waiting[i]) begin
        req[i]           = rq[i];
        req_op[2*i +: 2] = ops[2*i +: 2];
      end else if (drop[i]) begin
        req[i] = 1'b0;
      end
    end
    clr = c;
    a = '0; inc = 1'b0; dec = 1'b0; fast = 1'b0; sv = 1'b0; took = 1'b0; found = 1'b0;
    if (clr) begin
      sv = 1'b1;
    end else if (DEC_EN && m_pend) begin
      dec  = 1'b1;
      took = 1'b1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (!found && req[i]) begin
          found = 1'b1;
          a[i]  = 1'b1;
          op    = req_op[2*i +: 2];
          inc   = !op[0];
          dec   = op[0];
          fast  = op[1];
          m_ptr = (i + 1) % NREQ;
        end
      end
    end
    if (DEC_EN) begin
      m_pend = (m_tc == P - 1) || (m_pend && !took);
      m_tc   = (m_tc + 1) % P;
    end
    waiting = req & ~a;
    exp_q.push_back({a, inc, dec, fast, sv, inc | dec | sv});
    mon_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) drive('0, '0, 1'b0, '0);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({ack, res_inc, res_dec, res_fast, res_setval, busy} !== '0) begin
      errors++;
      $display("FAIL %s: outputs %b during reset, expected all zero", name,
               {ack, res_inc, res_dec, res_fast, res_setval, busy});
    end
  endtask

  task automatic do_reset(input string name);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_outputs(name);
    exp_q.delete();
    req = '0; clr = 1'b0; waiting = '0;
    m_ptr = 0; m_pend = 1'b0; m_tc = 0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  logic [NREQ-1:0]   r_req, r_drop;
  logic [2*NREQ-1:0] r_ops;

  initial begin
    // Reset held with traffic present: outputs must stay low.
    req = '1;
    clr = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset_hold");
    req = '0;
    clr = 1'b0;
    #1;
    rst_n = 1'b1;

    idle(20);

    drive(4'b0100, {2'b00, OP_FINC, 2'b00, 2'b00}, 1'b0, '0);
    idle(3);

    for (int j = 0; j < 16; j++) begin
      r_ops = (2*NREQ)'($urandom);
      drive('1, r_ops, 1'b0, '0);
    end
    idle(2);

    for (int j = 0; j < 3; j++) drive(4'b0010, {4{OP_DEC}}, 1'b1, '0);
    drive('0, '0, 1'b0, '0);
    idle(2);

    if (DEC_EN) begin
      for (int j = 0; j < 2 * P && !m_pend; j++) idle(1);
      drive(4'b0001, {4{OP_FDEC}}, 1'b0, '0);
      drive('0, '0, 1'b0, '0);
      idle(2);
    end

    for (int j = 0; j < 1500; j++) begin
      r_req  = NREQ'($urandom);
      r_ops  = (2*NREQ)'($urandom);
      r_drop = NREQ'($urandom) & NREQ'($urandom) & NREQ'($urandom);
      drive(r_req, r_ops, ($urandom_range(0, 15) == 0), r_drop);
    end

    // Move the pointer off 0, then reset with a decay pending.
    drive(4'b0010, {4{OP_INC}}, 1'b0, '0);
    idle(1);
    if (DEC_EN) begin
      for (int j = 0; j < 2 * P && !m_pend; j++) idle(1);
    end
    do_reset("reset_mid");
    for (int j = 0; j < 6; j++) begin
      r_ops = (2*NREQ)'($urandom);
      drive('1, r_ops, 1'b0, '0);
    end
    idle(4);

    @(posedge clk);
    #2;
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
